// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: requester/consumer bundle around the shared 4x4 multiplier arbiter
interface mult_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [4*N_REQ-1:0] req_a;
    logic [4*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [7:0]         rsp_p;
    logic [ID_W-1:0]    rsp_id;
    logic               busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p, rsp_id, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one 4x4 array multiplier; MULT_ARB_PIPE_EN adds a CALC stage with a product register
module mult_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input logic               clk,
    input logic               rst,
    mult_share_arbiter_if.slave bus
);
`ifdef MULT_ARB_PIPE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

    if (ID_W != $clog2(N_REQ) || N_REQ < 2 || N_REQ > 8) begin : g_bad_cfg
        $error("mult_share_arbiter: need 2 <= N_REQ <= 8 and ID_W == clog2(N_REQ)");
    end

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [3:0]      a_q, a_d, b_q, b_d;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;
    logic            hs;
    logic [ID_W:0]   idx;
    logic [7:0]      core_p;

    // Rotating priority search: walk downward so the smallest offset from ptr wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
            if (bus.req_valid[idx[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[ID_W-1:0];
            end
        end
    end

    // Grant only in IDLE and never while reset is held, so the acceptance edge is exactly hs
    assign hs            = (state_q == IDLE) && gnt_any && !rst;
    assign bus.req_ready = hs ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_id) : '0;

    // Shared array multiplier core: sum of shifted partial-product rows on the captured operands
    always_comb begin
        core_p = '0;
        for (int j = 0; j < 4; j++) core_p = core_p + (b_q[j] ? ({4'b0, a_q} << j) : 8'd0);
    end

    // Next-state: capture the granted slice on the request handshake, release on the response handshake
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: if (hs) begin
                a_d     = bus.req_a[{gnt_id, 2'b00} +: 4];
                b_d     = bus.req_b[{gnt_id, 2'b00} +: 4];
                id_d    = gnt_id;
                ptr_d   = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef MULT_ARB_PIPE_EN
                state_d = CALC;
`else
                state_d = RESP;
`endif
            end
`ifdef MULT_ARB_PIPE_EN
            CALC: state_d = RESP;
`endif
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and operand registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef MULT_ARB_PIPE_EN
    logic [7:0] p_q, p_d;

    assign p_d = (state_q == CALC) ? core_p : p_q;

    // Product register breaks the path from the operand registers through the multiplier
    always_ff @(posedge clk) begin
        if (rst) p_q <= '0;
        else     p_q <= p_d;
    end

    assign bus.rsp_p = p_q;
`else
    assign bus.rsp_p = core_p;
`endif

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state_q != IDLE);

    a_grant_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready));
    a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
        bus.rsp_valid && !bus.rsp_ready |=> bus.rsp_valid && $stable(bus.rsp_p) && $stable(bus.rsp_id));
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed vector table plus multi-cycle sequences for mult_share_arbiter (either MULT_ARB_PIPE_EN build)
module tb_mult_share_arbiter;
`ifdef MULT_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int id;
        int a;
        int b;
        int p;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[7];

    mult_share_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

    mult_share_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(posedge clk);
            #2;
            lat++;
        end
        if (!bus.rsp_valid) chk("rsp_timeout", int'(bus.rsp_valid), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic run_op(input int id, input int a, input int b, input int p);
        int lat;
        bus.req_a = '1;
        bus.req_b = '1;
        bus.req_a[4*id +: 4] = 4'(a);
        bus.req_b[4*id +: 4] = 4'(b);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'(1 << id);
        #1;
        chk("grant", int'(bus.req_ready), 1 << id);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        #1;
        wait_rsp(lat);
        chk("latency", lat, LAT);
        chk("product", int'(bus.rsp_p), p);
        chk("rsp_id", int'(bus.rsp_id), id);
        chk("busy_resp", int'(bus.busy), 1);
        @(posedge clk);
        #2;
        chk("busy_after", int'(bus.busy), 0);
        chk("valid_after", int'(bus.rsp_valid), 0);
    endtask

    initial begin
        int lat;
        int e;
        vecs[0] = '{2, 3, 5, 15};
        vecs[1] = '{0, 15, 15, 225};
        vecs[2] = '{1, 0, 9, 0};
        vecs[3] = '{3, 1, 12, 12};
        vecs[4] = '{2, 7, 9, 63};
        vecs[5] = '{1, 15, 1, 15};
        vecs[6] = '{0, 10, 13, 130};

        bus.req_valid = '1;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("ready_in_rst", int'(bus.req_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(bus.req_ready), 0);
        chk("rst_valid", int'(bus.rsp_valid), 0);
        chk("rst_p", int'(bus.rsp_p), 0);
        chk("rst_id", int'(bus.rsp_id), 0);
        chk("rst_busy", int'(bus.busy), 0);
        bus.req_valid = '0;
        rst = 1'b0;
        #1;

        for (int i = 0; i < 7; i++) run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[4*i +: 4] = 4'(i + 1);
            bus.req_b[4*i +: 4] = 4'(i + 2);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        #1;
        for (int k = 0; k < 8; k++) begin
            e = k % 4;
            chk("rr_grant", int'(bus.req_ready), 1 << e);
            @(posedge clk);
            #2;
            wait_rsp(lat);
            chk("rr_id", int'(bus.rsp_id), e);
            chk("rr_p", int'(bus.rsp_p), (e + 1) * (e + 2));
            @(posedge clk);
            #2;
        end
        bus.req_valid = '0;
        #1;

        bus.req_a[7:4] = 4'd6;
        bus.req_b[7:4] = 4'd7;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        chk("bp_grant", int'(bus.req_ready), 2);
        @(posedge clk);
        #2;
        bus.req_valid = 4'b1101;
        wait_rsp(lat);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", int'(bus.rsp_valid), 1);
            chk("bp_p", int'(bus.rsp_p), 42);
            chk("bp_id", int'(bus.rsp_id), 1);
            chk("bp_ready", int'(bus.req_ready), 0);
            chk("bp_busy", int'(bus.busy), 1);
            @(posedge clk);
            #2;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        chk("bp_idle_busy", int'(bus.busy), 0);
        chk("bp_next_grant", int'(bus.req_ready), 4);
        bus.req_valid = '0;
        @(posedge clk);
        #2;
        chk("bp_withdrawn", int'(bus.busy), 0);

        bus.req_a[11:8] = 4'd5;
        bus.req_b[11:8] = 4'd5;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0100;
        #1;
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        #1;
        wait_rsp(lat);
        chk("mid_p", int'(bus.rsp_p), 25);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_valid", int'(bus.rsp_valid), 0);
        chk("mid_p0", int'(bus.rsp_p), 0);
        chk("mid_id0", int'(bus.rsp_id), 0);
        chk("mid_busy", int'(bus.busy), 0);
        bus.req_a[3:0] = 4'd2;
        bus.req_b[3:0] = 4'd3;
        bus.req_a[15:12] = 4'd9;
        bus.req_b[15:12] = 4'd9;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1001;
        #1;
        chk("post_rst_grant", int'(bus.req_ready), 1);
        @(posedge clk);
        #2;
        wait_rsp(lat);
        chk("post_rst_id", int'(bus.rsp_id), 0);
        chk("post_rst_p", int'(bus.rsp_p), 6);
        @(posedge clk);
        #2;
        chk("post_rst_grant2", int'(bus.req_ready), 8);
        @(posedge clk);
        #2;
        bus.req_valid = '0;
        wait_rsp(lat);
        chk("post_rst_id2", int'(bus.rsp_id), 3);
        chk("post_rst_p2", int'(bus.rsp_p), 81);
        @(posedge clk);
        #2;
        chk("final_busy", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one combinational 4x4 unsigned array multiplier among `N_REQ` requesters. It sits between the requesting blocks and the multiplier core. It accepts one operand pair at a time over a valid/ready handshake, launches it through the core, and returns the 8-bit product tagged with the requester index over a second valid/ready handshake.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default 2: requester index width. Must equal clog2(`N_REQ`).

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `N_REQ`: bit i = requester i presents an operand pair.
- `req_a` in 4*`N_REQ`: multiplicand; requester i uses bits [4i+3:4i].
- `req_b` in 4*`N_REQ`: multiplier; requester i uses bits [4i+3:4i].
- `req_ready` out `N_REQ`: one-hot grant or all-zero.
- `rsp_valid` out 1: product available.
- `rsp_ready` in 1: consumer accepts the product.
- `rsp_p` out 8: product A*B, unsigned.
- `rsp_id` out `ID_W`: index of the requester that owns `rsp_p`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, CALC, RESP. CALC exists only with `MULT_ARB_PIPE_EN`.
- **IDLE**
  - If any `req_valid` bit is set, grant the first set bit searching upward from `ptr`, wrapping modulo `N_REQ`.
  - `req_ready[g]` is driven combinationally in the same cycle.
  - Handshake occurs when `req_valid[g] & req_ready[g]` at the clock edge. On that edge: capture `req_a`/`req_b` slice g and g into operand/id registers, set `ptr` <= (g+1) mod `N_REQ`, and go to CALC (or RESP if the macro is off).
  - If no request is valid, stay in IDLE; `ptr` is unchanged.
- **CALC**: register the core product; next state RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_p` and `rsp_id` are held stable until `rsp_valid & rsp_ready`.
  - On that handshake: next state IDLE.
- `req_ready` is all-zero in CALC and RESP. No new request is accepted in the same cycle as a response handshake.
- Arithmetic: zero-extend both operands to 8 bits; product range 0..225; no overflow is possible.
- A requester may deassert `req_valid` before it is granted; this has no effect.
- Operand changes on non-granted requesters are ignored.

## Timing
- Reset values: state IDLE, `ptr` 0, `req_ready` 0, `rsp_valid` 0, `rsp_p` 0x00, `rsp_id` 0, `busy` 0.
  - `req_ready` is forced to 0 while `rst` is high.
- Latency from request handshake edge T to first cycle with `rsp_valid`=1:
  - Macro off: T+1. `rsp_p` is the core output on the captured operands.
  - Macro on: T+2. `rsp_p` is the registered core output.
- Throughput: best case one operation per 2 cycles (macro off) or 3 cycles (macro on), with `rsp_ready` held high.
- Reset mid-operation (CALC or RESP): the operation is discarded with no response. All outputs return to reset values in the cycle after the reset edge.
- Simultaneous requests: exactly one grant per IDLE cycle. Every continuously-valid requester is served within `N_REQ` operations.

## Configuration
- `MULT_ARB_PIPE_EN`
  - Defined: the CALC state and an 8-bit product register are included; latency is 2. This breaks the path through the multiplier core for timing.
  - Undefined: no CALC state; `rsp_p` is taken directly from the core fed by the operand registers; latency is 1.
  - Interface and handshake rules are identical in both builds.

## Test plan
- **Single request:** requester 2 valid with a=3, b=5, `rsp_ready`=1.
  - `req_ready`=0b0100 for 1 cycle.
  - `rsp_valid` at T+1 (or T+2) with `rsp_p`=15, `rsp_id`=2.
  - Then IDLE and `busy`=0.
- **Extremes:** a=15, b=15 -> `rsp_p`=225. a=0, b=9 -> 0. a=1, b=12 -> 12.
- **Round-robin fairness:** all four requesters held valid for 8 operations -> grant order 0,1,2,3,0,1,2,3, with `rsp_id` matching each grant.
- **Backpressure:** `rsp_ready`=0 for 5 cycles after `rsp_valid` rises.
  - `rsp_p`/`rsp_id` stay constant, `req_ready`=0, `busy`=1.
  - `rsp_ready` rising -> one handshake, then IDLE the next cycle.
- **Reset mid-operation:** assert `rst` for 1 cycle while in RESP.
  - Next cycle: `rsp_valid`=0, `rsp_p`=0, `busy`=0.
  - A subsequent request from requester 3 with requester 0 also valid -> requester 0 is granted first (`ptr` reset to 0).
- **Build variants:** run the full suite with and without `MULT_ARB_PIPE_EN`. Check a latency of exactly 2 vs 1 cycles and identical products.
